// File: rtl/wbmem_dp.sv
// Dual-port pipelined Wishbone memory with byte lanes, read-first semantics and
// a fixed ack latency; port 0 wins same-word write collisions, port 1 is stalled.
module wbmem_dp #(
  parameter int DATA_W  = 32,
  parameter int AW      = 14,
  parameter int LATENCY = 2,
  parameter int ADR_LSB = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  bus0_cyc,
  input  logic                  bus0_stb,
  input  logic                  bus0_we,
  input  logic [31:0]           bus0_adr,
  input  logic [DATA_W/8-1:0]   bus0_sel,
  input  logic [DATA_W-1:0]     bus0_dat_i,
  output logic [DATA_W-1:0]     bus0_dat_o,
  output logic                  bus0_ack,
  output logic                  bus0_stall,

  input  logic                  bus1_cyc,
  input  logic                  bus1_stb,
  input  logic                  bus1_we,
  input  logic [31:0]           bus1_adr,
  input  logic [DATA_W/8-1:0]   bus1_sel,
  input  logic [DATA_W-1:0]     bus1_dat_i,
  output logic [DATA_W-1:0]     bus1_dat_o,
  output logic                  bus1_ack,
  output logic                  bus1_stall
);

  localparam int SEL_W = DATA_W / 8;
  localparam int NP    = 2;

  logic [NP-1:0]             cyc, stb, we, acc, ack;
  logic [NP-1:0][AW-1:0]     wadr;
  logic [NP-1:0][SEL_W-1:0]  sel;
  logic [NP-1:0][DATA_W-1:0] wdat, rdat;
  logic                      collide;
  logic                      unused_adr;

  logic [DATA_W-1:0] mem [2**AW];

  assign cyc  = {bus1_cyc, bus0_cyc};
  assign stb  = {bus1_stb, bus0_stb};
  assign we   = {bus1_we,  bus0_we};
  assign sel  = {bus1_sel, bus0_sel};
  assign wdat = {bus1_dat_i, bus0_dat_i};
  assign wadr = {bus1_adr[ADR_LSB+AW-1:ADR_LSB], bus0_adr[ADR_LSB+AW-1:ADR_LSB]};

  // Address bits outside the word field are ignored by design.
  assign unused_adr = ^{bus0_adr, bus1_adr};

  assign collide = cyc[0] && stb[0] && we[0] &&
                   cyc[1] && stb[1] && we[1] &&
                   (wadr[0] == wadr[1]);

  assign bus0_stall = 1'b0;
  assign bus1_stall = !rst_i && collide;

  assign acc[0] = !rst_i && cyc[0] && stb[0];
  assign acc[1] = !rst_i && cyc[1] && stb[1] && !collide;

  // NOTE: the memory array has no reset; contents must survive rst_i and a
  // reset branch would also prevent mapping onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < SEL_W; b++) begin
      if (acc[0] && we[0] && sel[0][b])
        mem[wadr[0]][8*b +: 8] <= wdat[0][8*b +: 8];
      if (acc[1] && we[1] && sel[1][b])
        mem[wadr[1]][8*b +: 8] <= wdat[1][8*b +: 8];
    end
  end

  for (genvar gp = 0; gp < NP; gp++) begin : g_port
    logic [LATENCY-1:0]             ack_pipe;
    logic [LATENCY-1:0][DATA_W-1:0] dat_pipe;

    // Dropping cyc aborts the cycle: every in-flight ack of this port is discarded.
    always_ff @(posedge clk_i) begin
      if (rst_i || !cyc[gp]) begin
        ack_pipe <= '0;
      end else begin
        ack_pipe[0] <= acc[gp];
        for (int i = 1; i < LATENCY; i++)
          ack_pipe[i] <= ack_pipe[i-1];
      end
    end

    // Sampling mem with the same edge as the write gives the pre-write word.
    always_ff @(posedge clk_i) begin
      if (acc[gp])
        dat_pipe[0] <= mem[wadr[gp]];
      for (int i = 1; i < LATENCY; i++)
        dat_pipe[i] <= dat_pipe[i-1];
    end

    assign ack[gp]  = ack_pipe[LATENCY-1] && cyc[gp];
    assign rdat[gp] = dat_pipe[LATENCY-1];
  end

  assign bus0_ack   = ack[0];
  assign bus1_ack   = ack[1];
  assign bus0_dat_o = rdat[0];
  assign bus1_dat_o = rdat[1];

endmodule
